// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg : core-wide constants and the instruction word type
// Rev 1.0   : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef logic [XLEN-1:0] instr_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with occupancy count and synchronous clear
// Rev 1.0   : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset: empty gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_issue_queue.sv
// ---------------------------------------------------------------------------
// instr_issue_queue : instruction prefetch queue feeding the core InsR input
// Rev 1.0           : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module instr_issue_queue #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter int              DEPTH    = 8,
  parameter logic [XLEN-1:0] NOP_WORD = riscv_pkg::NOP_WORD,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  localparam int             CW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [XLEN-1:0] wr_data,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic [XLEN-1:0] ins_r,
  output logic            ins_valid,
  output logic [XLEN-1:0] ins_pc,
  output logic [CW-1:0]   count
);

  logic [XLEN-1:0] head;
  logic [XLEN-1:0] next_pc;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  assign wr_ready = !fifo_full && !flush;
  assign push     = wr_valid && wr_ready;
  assign pop      = !flush && !stall && !fifo_empty;

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (head),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Flush outranks stall; ins_pc is left as-is since it is only meaningful with ins_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_r     <= NOP_WORD;
      ins_valid <= 1'b0;
      ins_pc    <= RESET_PC;
      next_pc   <= RESET_PC;
    end else if (flush) begin
      ins_r     <= NOP_WORD;
      ins_valid <= 1'b0;
      next_pc   <= flush_pc;
    end else if (!stall) begin
      if (!fifo_empty) begin
        ins_r     <= head;
        ins_valid <= 1'b1;
        ins_pc    <= next_pc;
        next_pc   <= next_pc + XLEN'(4);
      end else begin
        ins_r     <= NOP_WORD;
        ins_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_issue_queue : scoreboard bench for instr_issue_queue
// Rev 1.0              : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_issue_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [31:0] ins_r;
  logic        ins_valid;
  logic [31:0] ins_pc;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mq[$];
  int          mcount = 0;
  logic [31:0] mpc = '0;
  logic [31:0] exp_ins = NOP;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_pc = '0;

  instr_issue_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .stall     (stall),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .ins_r     (ins_r),
    .ins_valid (ins_valid),
    .ins_pc    (ins_pc),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mcount    = 0;
    mpc       = '0;
    exp_ins   = NOP;
    exp_valid = 1'b0;
    exp_pc    = '0;
  endtask

  // Inputs are set by the caller just after an edge; one clock is advanced here.
  task automatic tick();
    logic accept;
    #1;
    chk("wr_ready", {31'b0, wr_ready}, {31'b0, (mcount < 8) && !flush});
    accept = wr_valid && (mcount < 8) && !flush;
    if (flush) begin
      mq.delete();
      mcount    = 0;
      exp_ins   = NOP;
      exp_valid = 1'b0;
      mpc       = flush_pc;
    end else if (!stall) begin
      if (mcount > 0) begin
        exp_ins   = mq.pop_front();
        exp_valid = 1'b1;
        exp_pc    = mpc;
        mpc       = mpc + 32'd4;
        mcount--;
      end else begin
        exp_ins   = NOP;
        exp_valid = 1'b0;
      end
    end
    if (accept) begin
      mq.push_back(wr_data);
      mcount++;
    end
    @(posedge clk);
    #1;
    chk("ins_r", ins_r, exp_ins);
    chk("ins_valid", {31'b0, ins_valid}, {31'b0, exp_valid});
    chk("count", {28'b0, count}, 32'(mcount));
    if (exp_valid) chk("ins_pc", ins_pc, exp_pc);
  endtask

  task automatic put(input logic [31:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ins_r"}, ins_r, NOP);
    chk({tag, "_valid"}, {31'b0, ins_valid}, 32'd0);
    chk({tag, "_pc"}, ins_pc, 32'd0);
    chk({tag, "_count"}, {28'b0, count}, 32'd0);
    chk({tag, "_wr_ready"}, {31'b0, wr_ready}, 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_outputs("reset");
    model_reset();
    idle(2);

    // Back-to-back stream
    put(32'hfe01_0113);
    put(32'h0081_2e23);
    put(32'h0201_0413);
    idle(4);

    // Fill while stalled, refuse a ninth, then drain
    stall = 1'b1;
    for (int i = 0; i < 8; i++) put(32'h1000_0000 + 32'(i));
    chk("fill_count", {28'b0, count}, 32'd8);
    chk("fill_wr_ready", {31'b0, wr_ready}, 32'd0);
    put(32'hdead_beef);
    stall = 1'b0;
    idle(10);

    // Stall while 0x00500793 is on ins_r
    put(32'h0010_0093);
    put(32'h0050_0793);
    put(32'h00a0_0113);
    chk("stall_word", ins_r, 32'h0050_0793);
    stall = 1'b1;
    put(32'h00b0_0193);
    idle(2);
    stall = 1'b0;
    idle(4);

    // Flush with four queued words and a concurrent write
    stall = 1'b1;
    for (int i = 0; i < 4; i++) put(32'h2000_0000 + 32'(i));
    flush    = 1'b1;
    flush_pc = 32'h0000_0100;
    put(32'h00f7_07b3);
    flush    = 1'b0;
    stall    = 1'b0;
    chk("flush_count", {28'b0, count}, 32'd0);
    put(32'h0030_0213);
    put(32'h0040_0293);
    idle(3);

    // Async reset mid-cycle with five queued words
    stall = 1'b1;
    for (int i = 0; i < 5; i++) put(32'h3000_0000 + 32'(i));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    #2;
    rst_n = 1'b1;
    model_reset();
    stall = 1'b0;
    put(32'h0060_0313);
    put(32'h0070_0393);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
